spi_slave_regfile: RTL and testbench

SPI slave endpoint that terminates the 41-bit frames produced by the team's SPI master controller. It decodes each frame as a write or read command to an internal 32-bit register file. On reads, it returns 32 bits of data on MISO in the bit slots the master samples. It runs in the same SCLK domain as the master and is the downstream peer on spi_clk/spi_mosi/spi_cs/spi_miso.

---
 rtl/spi_frame_pkg.sv | 17 +
 rtl/spi_regfile.sv | 31 +++
 rtl/spi_slave_regfile.sv | 140 ++++++++++++++
 tb/tb_spi_slave_regfile.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// Shared SPI frame layout for the master controller and the register-file slave.
// A frame is 41 bits, sent MSB first: {wr, addr[7:0], data[31:0]}.
package spi_frame_pkg;
  localparam int FRAME_W  = 41;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int WR_BIT   = 40;
  localparam int ADDR_MSB = 39;
  localparam int ADDR_LSB = 32;
  localparam int CMD_LAST = FRAME_W - DATA_W - 1;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} spi_state_e;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int num_regs);
    return int'({24'd0, addr}) < num_regs;
  endfunction
endpackage

// File: rtl/spi_regfile.sv
// NUM_REGS x 32 register array: one synchronous write port, two combinational read ports.
// Reads outside the array return ERR_DATA; out-of-range writes are ignored.
module spi_regfile import spi_frame_pkg::*; #(
  parameter int                NUM_REGS = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] spi_raddr,
  output logic [DATA_W-1:0] spi_rdata,
  input  logic [ADDR_W-1:0] host_raddr,
  output logic [DATA_W-1:0] host_rdata
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && addr_in_range(waddr, NUM_REGS)) begin
      regs[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  assign spi_rdata  = addr_in_range(spi_raddr, NUM_REGS)  ? regs[spi_raddr[IDX_W-1:0]]  : ERR_DATA;
  assign host_rdata = addr_in_range(host_raddr, NUM_REGS) ? regs[host_raddr[IDX_W-1:0]] : ERR_DATA;
endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave terminating 41-bit read/write frames into a 32-bit register file.
// MOSI sampled on spi_clk rise, MISO updated on fall; write commits on the 41st rise.
module spi_slave_regfile import spi_frame_pkg::*; #(
  parameter int                NUM_REGS = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              SCLK,
  input  logic              SRESET,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic              spi_cs,
  output logic              spi_miso,
  input  logic [ADDR_W-1:0] host_addr,
  output logic [DATA_W-1:0] host_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_strobe,
  output logic              frame_err
);
  spi_state_e        state, state_nxt;
  logic              spi_clk_q, rise, fall;
  logic [5:0]        bit_cnt;
  logic [7:0]        cmd_sr;
  logic [8:0]        cmd_word;
  logic [DATA_W-2:0] wr_sr;
  logic [DATA_W-1:0] wr_word, rd_sr, spi_rdata;
  logic [ADDR_W-1:0] addr_q;
  logic              is_wr, abort, cmd_last, miso_first, frame_last, commit_ok;

  assign rise       = spi_clk & ~spi_clk_q;
  assign fall       = ~spi_clk & spi_clk_q;
  assign cmd_word   = {cmd_sr, spi_mosi};
  assign wr_word    = {wr_sr, spi_mosi};
  // spi_cs high outranks any clock edge seen in the same cycle.
  assign abort      = spi_cs && (state == CMD || state == DATA);
  assign cmd_last   = !spi_cs && state == CMD && rise && bit_cnt == 6'(CMD_LAST);
  assign miso_first = !spi_cs && state == CMD && fall && bit_cnt == 6'(CMD_LAST + 1);
  assign frame_last = !spi_cs && state == DATA && rise && bit_cnt == 6'(FRAME_W - 1);
  assign commit_ok  = frame_last && is_wr && addr_in_range(addr_q, NUM_REGS);

  always_ff @(posedge SCLK) begin
    if (SRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!spi_cs) state_nxt = CMD;
      CMD:     if (spi_cs) state_nxt = IDLE; else if (miso_first) state_nxt = DATA;
      DATA:    if (spi_cs) state_nxt = IDLE; else if (frame_last) state_nxt = DONE;
      DONE:    if (spi_cs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge SCLK) begin
    if (SRESET) begin
      spi_clk_q <= 1'b0;
      spi_miso  <= 1'b0;
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      wr_sr     <= '0;
      rd_sr     <= '0;
      addr_q    <= '0;
      is_wr     <= 1'b0;
    end else begin
      spi_clk_q <= spi_clk;
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      if (abort) frame_err <= 1'b1;
      case (state)
        IDLE: begin
          bit_cnt  <= '0;
          spi_miso <= 1'b0;
        end
        CMD: if (!spi_cs) begin
          if (rise) begin
            cmd_sr  <= cmd_word[7:0];
            bit_cnt <= bit_cnt + 6'd1;
          end
          if (cmd_last) begin
            addr_q <= cmd_word[7:0];
            is_wr  <= cmd_word[8];
            if (cmd_word[8]) begin
              rd_sr <= '0;
            end else begin
              rd_sr     <= spi_rdata;
              rd_strobe <= 1'b1;
              if (!addr_in_range(cmd_word[7:0], NUM_REGS)) frame_err <= 1'b1;
            end
          end
          if (miso_first) begin
            spi_miso <= rd_sr[DATA_W-1];
            rd_sr    <= {rd_sr[DATA_W-2:0], 1'b0};
          end
        end
        DATA: if (!spi_cs) begin
          if (rise) begin
            bit_cnt <= bit_cnt + 6'd1;
            if (is_wr) wr_sr <= wr_word[DATA_W-2:0];
          end
          if (fall) begin
            spi_miso <= rd_sr[DATA_W-1];
            rd_sr    <= {rd_sr[DATA_W-2:0], 1'b0};
          end
          if (frame_last && is_wr) begin
            if (commit_ok) begin
              wr_strobe <= 1'b1;
              wr_addr   <= addr_q;
              wr_data   <= wr_word;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        DONE:    spi_miso <= 1'b0;
        default: spi_miso <= 1'b0;
      endcase
    end
  end

  spi_regfile #(.NUM_REGS(NUM_REGS), .ERR_DATA(ERR_DATA)) u_regfile (
    .clk        (SCLK),
    .rst        (SRESET),
    .we         (commit_ok),
    .waddr      (addr_q),
    .wdata      (wr_word),
    .spi_raddr  (cmd_word[7:0]),
    .spi_rdata  (spi_rdata),
    .host_raddr (host_addr),
    .host_rdata (host_rdata)
  );
endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: a bit-level SPI master drives frames, a register-array
// model predicts writes/reads, and a monitor scores strobes and received read words.
module tb_spi_slave_regfile;
  localparam int          NUM_REGS = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic        SCLK = 1'b0, SRESET = 1'b1;
  logic        spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs = 1'b1;
  logic        spi_miso, wr_strobe, rd_strobe, frame_err;
  logic [7:0]  host_addr = 8'd0, wr_addr;
  logic [31:0] host_rdata, wr_data;

  int total = 0, bad = 0;
  logic [31:0] model_regs [256];
  bit          model_err = 1'b0;
  logic [39:0] exp_wr_q [$];
  logic [31:0] exp_rd_q [$];
  int          exp_wr_cnt = 0, exp_rd_cnt = 0, got_wr_cnt = 0, got_rd_cnt = 0;
  logic        rx_vld = 1'b0;
  logic [31:0] rx_dat = '0;
  logic [39:0] mon_wr;
  logic [31:0] mon_rd;

  always #5 SCLK = ~SCLK;

  spi_slave_regfile #(.NUM_REGS(NUM_REGS), .ERR_DATA(ERR_DATA)) dut (
    .SCLK(SCLK), .SRESET(SRESET), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
    .spi_miso(spi_miso), .host_addr(host_addr), .host_rdata(host_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_strobe(rd_strobe), .frame_err(frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    return (int'(a) < NUM_REGS) ? model_regs[a] : ERR_DATA;
  endfunction

  always @(negedge SCLK) begin
    if (wr_strobe) begin
      got_wr_cnt++;
      if (exp_wr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_unexpected: got addr %h data %h, expected no write", wr_addr, wr_data);
      end else begin
        mon_wr = exp_wr_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(mon_wr[39:32]));
        check("wr_data", wr_data, mon_wr[31:0]);
      end
    end
    if (rd_strobe) got_rd_cnt++;
    if (rx_vld) begin
      if (exp_rd_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected: got %h, expected no read", rx_dat);
      end else begin
        mon_rd = exp_rd_q.pop_front();
        check("rd_data", rx_dat, mon_rd);
      end
    end
  end

  // Bit-level master: one SCLK per spi_clk phase, MISO sampled before the rising edge lands.
  task automatic spi_bits(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                          input int nbits, output logic [31:0] rx, output bit cmd_quiet);
    logic [40:0] f;
    f = {wr, addr, data};
    rx = '0;
    cmd_quiet = 1'b1;
    spi_cs = 1'b0;
    @(posedge SCLK); #1;
    for (int k = 0; k < nbits; k++) begin
      spi_mosi = f[40-k];
      spi_clk  = 1'b0;
      @(posedge SCLK); #1 spi_clk = 1'b1;
      @(negedge SCLK);
      if (k < 9) begin
        if (spi_miso !== 1'b0) cmd_quiet = 1'b0;
      end else begin
        rx = {rx[30:0], spi_miso};
      end
      @(posedge SCLK); #1;
    end
    spi_clk = 1'b0;
  endtask

  task automatic end_frame();
    @(posedge SCLK); #1 spi_cs = 1'b1;
    @(posedge SCLK); #1;
    @(posedge SCLK); #1;
  endtask

  task automatic do_frame(input bit wr, input logic [7:0] addr, input logic [31:0] data);
    logic [31:0] rx;
    bit          quiet;
    if (wr) begin
      if (int'(addr) < NUM_REGS) begin
        model_regs[addr] = data;
        exp_wr_q.push_back({addr, data});
        exp_wr_cnt++;
      end else begin
        model_err = 1'b1;
      end
    end else begin
      exp_rd_q.push_back(model_read(addr));
      exp_rd_cnt++;
      if (int'(addr) >= NUM_REGS) model_err = 1'b1;
    end
    spi_bits(wr, addr, data, 41, rx, quiet);
    end_frame();
    check("frame_err", 32'(frame_err), 32'(model_err));
    if (!wr) begin
      check("miso_cmd_quiet", 32'(quiet), 32'd1);
      rx_dat = rx;
      rx_vld = 1'b1;
      @(posedge SCLK); #1 rx_vld = 1'b0;
      @(posedge SCLK); #1;
    end
  endtask

  task automatic host_chk(input logic [7:0] a);
    host_addr = a;
    #1;
    check("host_rdata", host_rdata, model_read(a));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within the time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rx;
    bit          quiet;
    bit          wr;
    logic [7:0]  a;
    logic [31:0] d;
    for (int i = 0; i < 256; i++) model_regs[i] = '0;

    repeat (3) @(posedge SCLK);
    @(negedge SCLK);
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_rd_strobe", 32'(rd_strobe), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    @(posedge SCLK); #1 SRESET = 1'b0;
    @(posedge SCLK); #1;
    host_chk(8'h00);

    do_frame(1'b1, 8'h03, 32'hA5A5_1234);
    host_chk(8'h03);
    do_frame(1'b0, 8'h03, $urandom);
    do_frame(1'b0, 8'h20, $urandom);
    host_chk(8'h03);
    host_chk(8'h20);

    spi_bits(1'b1, 8'h05, 32'h1357_9BDF, 20, rx, quiet);
    end_frame();
    model_err = 1'b1;
    check("abort_frame_err", 32'(frame_err), 32'd1);
    host_chk(8'h05);
    do_frame(1'b1, 8'h05, 32'h0BAD_F00D);
    host_chk(8'h05);

    exp_rd_cnt++;
    spi_bits(1'b0, 8'h03, 32'd0, 25, rx, quiet);
    SRESET = 1'b1; spi_cs = 1'b1; spi_clk = 1'b0;
    @(posedge SCLK); #1;
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
    model_err = 1'b0;
    check("mid_rst_miso", 32'(spi_miso), 32'd0);
    check("mid_rst_frame_err", 32'(frame_err), 32'd0);
    host_chk(8'h03);
    host_chk(8'h05);
    @(posedge SCLK); #1 SRESET = 1'b0;
    @(posedge SCLK); #1;
    do_frame(1'b0, 8'h00, $urandom);

    for (int i = 0; i < 16; i++) do_frame(1'b1, 8'(i), 32'h5A5A_0000 ^ 32'(i));
    for (int i = 0; i < 16; i++) do_frame(1'b0, 8'(i), $urandom);

    for (int n = 0; n < 30; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 19));
      d  = $urandom;
      do_frame(wr, a, d);
      host_chk(8'($urandom_range(0, 23)));
    end

    for (int i = 0; i < NUM_REGS; i++) host_chk(8'(i));
    host_chk(8'hFF);
    repeat (4) @(posedge SCLK);
    #1;
    check("wr_strobe_count", 32'(got_wr_cnt), 32'(exp_wr_cnt));
    check("rd_strobe_count", 32'(got_rd_cnt), 32'(exp_rd_cnt));
    check("wr_q_left", 32'(exp_wr_q.size()), 32'd0);
    check("rd_q_left", 32'(exp_rd_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
